// File: rtl/lcd_msg_streamer_pkg.sv
// Shared types and message text for the LCD character streamer.
// Text constants are left-justified and padded with spaces to full width.
package lcd_pkg;

    localparam logic [7:0] CLR_CMD_DEF = 8'h01;
    localparam int         MSG_COUNT   = 8;
    localparam int         MAX_LEN     = 16;
    localparam logic [7:0] PAD         = 8'h20;

    typedef logic [2:0] msg_idx_t;

    typedef logic [8*MAX_LEN-1:0] msg_text_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CHARS,
        ST_DONE
    } state_t;

    localparam msg_text_t MSG_READY = {"READY", {11{PAD}}};
    localparam msg_text_t MSG_ON    = {"ON",    {14{PAD}}};
    localparam msg_text_t MSG_OFF   = {"OFF",   {13{PAD}}};
    localparam msg_text_t MSG_UP    = {"UP",    {14{PAD}}};
    localparam msg_text_t MSG_DOWN  = {"DOWN",  {12{PAD}}};
    localparam msg_text_t MSG_LEFT  = {"LEFT",  {12{PAD}}};
    localparam msg_text_t MSG_RIGHT = {"RIGHT", {11{PAD}}};
    localparam msg_text_t MSG_STOP  = {"STOP",  {12{PAD}}};

    localparam msg_text_t MSG_TEXT [MSG_COUNT] = '{
        MSG_READY, MSG_ON, MSG_OFF, MSG_UP,
        MSG_DOWN, MSG_LEFT, MSG_RIGHT, MSG_STOP
    };

endpackage

// File: rtl/lcd_msg_streamer_if.sv
// Character handshake between the streamer and lcd_driver.
// The master presents bytes; the slave accepts them with char_ready.
interface lcd_msg_streamer_if;
    logic [7:0] char_data;
    logic       char_is_cmd;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_data,
        output char_is_cmd,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_data,
        input  char_is_cmd,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/lcd_msg_streamer_rom.sv
// Combinational message ROM: (sel, column) -> ASCII byte.
// Column 0 is the leftmost character of the line.
import lcd_pkg::*;

module lcd_msg_rom #(
    parameter int IW = 4
) (
    input  msg_idx_t        sel,
    input  logic [IW-1:0]   idx,
    output logic [7:0]      data
);
    msg_text_t  txt;
    msg_text_t  shifted;
    logic [3:0] col;

    assign txt     = MSG_TEXT[sel];
    assign col     = 4'(idx);
    // Shift the wanted byte up into the top lane.
    assign shifted = txt << {col, 3'b000};
    assign data    = shifted[8*MAX_LEN-1 -: 8];
endmodule

// File: rtl/lcd_msg_streamer.sv
// Streams a clear command plus one fixed-width text line per request.
// Requests arriving while busy are held in a 1-deep, newest-wins slot.
import lcd_pkg::*;

module lcd_msg_streamer #(
    parameter int         MSG_LEN = 16,
    parameter logic [7:0] CLR_CMD = CLR_CMD_DEF
) (
    input  logic                clk,
    input  logic                rstb,
    input  msg_idx_t            msg_sel,
    input  logic                msg_req,
    output logic                busy,
    output logic                msg_done,
    lcd_msg_streamer_if.master  ch
);
    localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(MSG_LEN - 1);

    state_t        state_q, state_nx;
    logic [IW-1:0] idx_q, idx_nx;
    msg_idx_t      cur_q, cur_nx;
    msg_idx_t      pend_sel_q, pend_sel_nx;
    logic          pend_q, pend_nx;
    logic          busy_q, busy_nx;
    logic          done_q, done_nx;
    logic [7:0]    data_q, data_nx;
    logic          cmd_q, cmd_nx;
    logic          valid_q, valid_nx;

    logic          xfer;
    logic [IW-1:0] rom_idx;
    logic [7:0]    rom_byte;

    assign xfer    = valid_q && ch.char_ready;
    // Address of the byte to present after the current transfer.
    assign rom_idx = (state_q == ST_CHARS) ? idx_q + 1'b1 : '0;

    lcd_msg_rom #(.IW(IW)) u_rom (
        .sel  (cur_q),
        .idx  (rom_idx),
        .data (rom_byte)
    );

    always_comb begin
        state_nx    = state_q;
        idx_nx      = idx_q;
        cur_nx      = cur_q;
        pend_sel_nx = pend_sel_q;
        pend_nx     = pend_q;
        busy_nx     = busy_q;
        done_nx     = 1'b0;
        data_nx     = data_q;
        cmd_nx      = cmd_q;
        valid_nx    = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (msg_req) begin
                    state_nx = ST_CLEAR;
                    cur_nx   = msg_sel;
                    valid_nx = 1'b1;
                    data_nx  = CLR_CMD;
                    cmd_nx   = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (msg_req) begin
                    pend_nx     = 1'b1;
                    pend_sel_nx = msg_sel;
                end
                if (xfer) begin
                    state_nx = ST_CHARS;
                    idx_nx   = '0;
                    data_nx  = rom_byte;
                    cmd_nx   = 1'b0;
                end
            end
            ST_CHARS: begin
                if (msg_req) begin
                    pend_nx     = 1'b1;
                    pend_sel_nx = msg_sel;
                end
                if (xfer) begin
                    if (idx_q == LAST) begin
                        state_nx = ST_DONE;
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx  = idx_q + 1'b1;
                        data_nx = rom_byte;
                    end
                end
            end
            ST_DONE: begin
                // A request in this very cycle beats the held one.
                if (msg_req || pend_q) begin
                    state_nx = ST_CLEAR;
                    cur_nx   = msg_req ? msg_sel : pend_sel_q;
                    pend_nx  = 1'b0;
                    valid_nx = 1'b1;
                    data_nx  = CLR_CMD;
                    cmd_nx   = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cur_q      <= '0;
            pend_sel_q <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= 8'h00;
            cmd_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_nx;
            idx_q      <= idx_nx;
            cur_q      <= cur_nx;
            pend_sel_q <= pend_sel_nx;
            pend_q     <= pend_nx;
            busy_q     <= busy_nx;
            done_q     <= done_nx;
            data_q     <= data_nx;
            cmd_q      <= cmd_nx;
            valid_q    <= valid_nx;
        end
    end

    assign busy           = busy_q;
    assign msg_done       = done_q;
    assign ch.char_data   = data_q;
    assign ch.char_is_cmd = cmd_q;
    assign ch.char_valid  = valid_q;
endmodule

// File: tb/tb_lcd_msg_streamer.sv
// Scoreboard bench for lcd_msg_streamer: randomized requests and
// ready patterns checked against a message-level reference model.
module tb_lcd_msg_streamer;

    logic       clk;
    logic       rstb;
    logic [2:0] msg_sel;
    logic       msg_req;
    logic       busy;
    logic       msg_done;

    lcd_msg_streamer_if ch_if();

    lcd_msg_streamer #(
        .MSG_LEN (16),
        .CLR_CMD (8'h01)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .msg_sel  (msg_sel),
        .msg_req  (msg_req),
        .busy     (busy),
        .msg_done (msg_done),
        .ch       (ch_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string names [8] = '{
        "READY", "ON", "OFF", "UP",
        "DOWN", "LEFT", "RIGHT", "STOP"
    };

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int cyc   = 0;
    int rmode = 0;

    logic [8:0] expq [$];
    logic       pend_v   = 1'b0;
    logic [2:0] pend_sel = '0;
    logic       done_win = 1'b0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Expected line: clear command, text, space padding to 16.
    task automatic push_msg(input int s);
        logic [7:0] b;
        expq.push_back({1'b1, 8'h01});
        for (int c = 0; c < 16; c++) begin
            b = (c < names[s].len()) ? 8'(names[s][c]) : 8'h20;
            expq.push_back({1'b0, b});
        end
    endtask

    // Monitor and model: check what the DUT shows now, then
    // advance the model by the edge that follows.
    always @(negedge clk) begin
        cyc++;
        if (!rstb) begin
            expq.delete();
            pend_v   = 1'b0;
            done_win = 1'b0;
        end else begin
            chk("busy", 32'(busy),
                32'(expq.size() > 0 || done_win));
            chk("msg_done", 32'(msg_done), 32'(done_win));
            chk("valid", 32'(ch_if.char_valid),
                32'(expq.size() > 0));
            if (ch_if.char_valid && expq.size() > 0)
                chk("byte",
                    32'({ch_if.char_is_cmd, ch_if.char_data}),
                    32'(expq[0]));
            if (done_win) begin
                if (msg_req) begin
                    pend_v   = 1'b1;
                    pend_sel = msg_sel;
                end
                if (pend_v) push_msg(int'(pend_sel));
                pend_v   = 1'b0;
                done_win = 1'b0;
            end else if (msg_req) begin
                if (expq.size() > 0) begin
                    pend_v   = 1'b1;
                    pend_sel = msg_sel;
                end else begin
                    push_msg(int'(msg_sel));
                end
            end
            if (ch_if.char_valid && ch_if.char_ready
                && expq.size() > 0) begin
                void'(expq.pop_front());
                xfers++;
                if (expq.size() == 0) done_win = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       ch_if.char_ready = 1'b1;
            1:       ch_if.char_ready = (cyc % 3 == 2);
            default: ch_if.char_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic req(input logic [2:0] s);
        msg_sel = s;
        msg_req = 1'b1;
        @(posedge clk);
        #1;
        msg_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((expq.size() > 0 || done_win || pend_v)
               && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL idle_timeout: got busy want idle");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(ch_if.char_valid), 0);
        chk({tag, "_data"}, 32'(ch_if.char_data), 0);
        chk({tag, "_cmd"}, 32'(ch_if.char_is_cmd), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(msg_done), 0);
    endtask

    initial begin
        int n;
        int base;
        rstb             = 1'b0;
        msg_req          = 1'b0;
        msg_sel          = '0;
        ch_if.char_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rstb = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rmode = 0;
        req(3'd5);
        wait_idle(200);

        rmode = 1;
        req(3'd0);
        wait_idle(300);

        rmode = 0;
        req(3'd1);
        repeat (3) @(posedge clk);
        #1;
        req(3'd2);
        repeat (2) @(posedge clk);
        #1;
        req(3'd7);
        wait_idle(300);

        req(3'd4);
        n = 0;
        while (!msg_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(msg_done), 1);
        req(3'd3);
        wait_idle(300);

        base = xfers;
        req(3'd6);
        n = 0;
        while (xfers < base + 8 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("xfer8_seen", 32'(xfers - base), 8);
        #1;
        rstb = 1'b0;
        #1;
        chk_reset_outputs("async");
        repeat (3) @(posedge clk);
        #1;
        rstb = 1'b1;
        repeat (15) @(posedge clk);
        #1;

        rmode = 2;
        req(3'd2);
        for (int i = 0; i < 12; i++) begin
            msg_sel = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        wait_idle(300);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 25)) @(posedge clk);
            #1;
            req(3'($urandom_range(0, 7)));
        end
        wait_idle(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
